key_typematic: RTL and testbench
================================

KEY_TYPEMATIC -- requirements
Module: key_typematic

Interface
REQ-001 The module SHALL have parameter NKEYS, default 5: number of key channels.
REQ-002 The module SHALL have parameter DEBOUNCE, default 3: number of consecutive stable i_en ticks before the debounced level changes (range 1..255).
REQ-003 The module SHALL have parameter REPEAT_DELAY, default 4: i_en ticks from press event to first repeat event (range 1..65535).
REQ-004 The module SHALL have parameter REPEAT_PERIOD, default 2: i_en ticks between successive repeat events (range 1..65535).
REQ-005 The module SHALL have parameter CODES, default {8'h08,8'h41,8'h04,8'h03,8'h02}: ascii-ex code per key, key k in bits [8k+7:8k].
REQ-006 The module SHALL have parameter REPEAT_MASK, default 5'b10111: bit k=1 enables auto-repeat on key k.
REQ-007 The module SHALL have parameter TYPE_MASK, default 5'b11000: bit k=1 marks key k as a typing key.
REQ-008 The module SHALL have ports, in order: clk in 1 (single clock); i_arst in 1 (asynchronous reset, active-high); i_sclr in 1 (synchronous clear); i_en in 1 (sampling tick); i_key_n in NKEYS (raw keys, active-low, asynchronous); i_asciiex_rdy in 1 (consumer ready); o_asciiex out 8 (code); o_type out 1 (typing key); o_asciiex_en out 1 (valid); o_overrun out 1 (event-lost pulse).

Function
REQ-009 Each key channel SHALL pass ~i_key_n[k] through a 2-flop synchronizer clocked every clk.
REQ-010 The debounce counter SHALL advance only on i_en=1 cycles; it resets when the synchronized sample differs from the debounced level and otherwise increments; on reaching DEBOUNCE the debounced level toggles and the counter clears.
REQ-011 A debounced 0->1 transition SHALL raise a one-cycle press event.
REQ-012 Per-key repeat FSM SHALL use states IDLE, DELAY, REPEAT: IDLE->DELAY on press with counter=REPEAT_DELAY (REPEAT_MASK[k]=1 only); DELAY/REPEAT decrement on i_en; at 0 emit repeat event, load REPEAT_PERIOD, go to REPEAT; any state->IDLE on debounced 1->0.
REQ-013 A press or repeat event SHALL set pending[k] at the next clk edge.
REQ-014 If pending[k] is already set when a new event arrives for key k and is not being consumed in that cycle, the event SHALL be dropped and o_overrun SHALL pulse for exactly one cycle.
REQ-015 The output register SHALL load when o_asciiex_en=0 or i_asciiex_rdy=1, taking the lowest-index set pending bit, clearing it in the same edge, and setting o_asciiex=CODES[k], o_type=TYPE_MASK[k], o_asciiex_en=1.
REQ-016 If no pending bit is set at a load opportunity, o_asciiex_en SHALL fall to 0 while o_asciiex/o_type hold their last values.
REQ-017 While o_asciiex_en=1 and i_asciiex_rdy=0, o_asciiex and o_type SHALL remain stable.
REQ-018 Latency from the synchronized sample to o_asciiex_en SHALL be DEBOUNCE ticks + 2 clk, with no backpressure and no lower-index pending.
REQ-019 Simultaneous events on several keys SHALL all be retained and emitted one per accepted transfer, lowest index first.
REQ-020 i_en=0 SHALL freeze debounce and repeat counters only; output handshake continues.

Reset
REQ-021 i_arst=1 SHALL immediately clear synchronizers, debounced levels, counters, FSMs (IDLE), pending, o_asciiex=8'h00, o_type=0, o_asciiex_en=0, o_overrun=0.
REQ-022 i_sclr=1 SHALL produce the same state as i_arst at the next clk edge, with priority over all other updates.
REQ-023 A key held through reset release SHALL produce a press event only after DEBOUNCE stable ticks.

Structure
REQ-024 Package key_typematic_pkg SHALL hold the FSM state encoding (IDLE/DELAY/REPEAT) and the default CODES/REPEAT_MASK/TYPE_MASK constants.
REQ-025 Sub-module key_channel (synchronizer, debounce, repeat FSM, event output) SHALL be instantiated NKEYS times; the pending register and priority/output logic SHALL live in key_typematic.
REQ-026 Counter widths SHALL be $clog2(parameter+1).

Verification (defaults, i_en=1 every cycle, i_asciiex_rdy=1 unless stated)
REQ-027 Key3 low for 2 cycles, then low for 10 cycles -> no event for the glitch; exactly one 8'h41 event with o_type=1, and no repeat.
REQ-028 Key0 held for 20 ticks -> 8'h02 press event, then repeats at +4, +6, +8... ticks, o_type=0; release -> no further events.
REQ-029 Key4 and key1 debounced in the same cycle -> 8'h03 transfer, then 8'h08 transfer on the next cycle; o_overrun=0.
REQ-030 Key0 repeating with i_asciiex_rdy=0 for 12 cycles -> o_asciiex held at 8'h02 and stable; o_overrun pulses on each dropped repeat; after ready, one buffered event is emitted.
REQ-031 i_arst asserted mid-REPEAT on key0 -> all outputs 0 asynchronously; after release, with key still held -> new press event after 3 ticks.

Source files
------------

// File: rtl/key_typematic_pkg.sv
// Shared types and default key map for the typematic keyboard front end.
package key_typematic_pkg;

  // Per-key auto-repeat state.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDelay  = 2'd1,
    StRepeat = 2'd2
  } rep_state_e;

  localparam int unsigned DefNkeys      = 5;
  localparam logic [39:0] DefCodes      = {8'h08, 8'h41, 8'h04, 8'h03, 8'h02};
  localparam logic [4:0]  DefRepeatMask = 5'b10111;
  localparam logic [4:0]  DefTypeMask   = 5'b11000;

endpackage

// File: rtl/key_channel.sv
// One key: synchronizer, debouncer, auto-repeat FSM and a registered event pulse.
module key_channel
  import key_typematic_pkg::*;
#(
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned REPEAT_DELAY  = 4,
  parameter int unsigned REPEAT_PERIOD = 2,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic i_arst,
  input  logic i_sclr,
  input  logic i_en,
  input  logic i_key_n,
  output logic o_event
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned RpMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RpW   = $clog2(RpMax + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);

  logic [1:0]     r_sync;
  logic           r_deb;
  logic [DbW-1:0] r_db_cnt, w_db_cnt_d;
  rep_state_e     r_state, w_state_d;
  logic [RpW-1:0] r_rep_cnt, w_rep_cnt_d;
  logic           r_event;
  logic           w_sample, w_toggle, w_press, w_release, w_rep_evt;

  assign w_sample  = r_sync[1];
  // The tick that completes DEBOUNCE differing samples flips the level.
  assign w_toggle  = i_en && (w_sample != r_deb) && (r_db_cnt == DbLast);
  assign w_press   = w_toggle && !r_deb;
  assign w_release = w_toggle && r_deb;
  assign o_event   = r_event;

  // Debounce counter: counts consecutive ticks the sample disagrees with the level.
  always_comb begin
    w_db_cnt_d = r_db_cnt;
    if (i_en) begin
      if ((w_sample == r_deb) || w_toggle) w_db_cnt_d = '0;
      else                                 w_db_cnt_d = r_db_cnt + DbW'(1);
    end
  end

  // Repeat FSM next state; a release always wins and suppresses that tick's repeat.
  always_comb begin
    w_state_d   = r_state;
    w_rep_cnt_d = r_rep_cnt;
    w_rep_evt   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_press && REPEAT_EN) begin
          w_state_d   = StDelay;
          w_rep_cnt_d = RpW'(REPEAT_DELAY);
        end
      end
      StDelay, StRepeat: begin
        if (i_en) begin
          if (r_rep_cnt <= RpW'(1)) begin
            w_rep_evt   = 1'b1;
            w_rep_cnt_d = RpW'(REPEAT_PERIOD);
            w_state_d   = StRepeat;
          end else begin
            w_rep_cnt_d = r_rep_cnt - RpW'(1);
          end
        end
      end
      default: begin
        w_state_d   = StIdle;
        w_rep_cnt_d = '0;
      end
    endcase
    if (w_release) begin
      w_state_d   = StIdle;
      w_rep_cnt_d = '0;
      w_rep_evt   = 1'b0;
    end
  end

  // All channel state; synchronous clear mirrors the asynchronous reset.
  always_ff @(posedge clk or posedge i_arst) begin
    if (i_arst) begin
      r_sync    <= '0;
      r_deb     <= 1'b0;
      r_db_cnt  <= '0;
      r_state   <= StIdle;
      r_rep_cnt <= '0;
      r_event   <= 1'b0;
    end else if (i_sclr) begin
      r_sync    <= '0;
      r_deb     <= 1'b0;
      r_db_cnt  <= '0;
      r_state   <= StIdle;
      r_rep_cnt <= '0;
      r_event   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], ~i_key_n};
      r_db_cnt  <= w_db_cnt_d;
      if (w_toggle) r_deb <= ~r_deb;
      r_state   <= w_state_d;
      r_rep_cnt <= w_rep_cnt_d;
      r_event   <= w_press || w_rep_evt;
    end
  end

endmodule

// File: rtl/key_typematic.sv
// Multi-key typematic encoder: per-key channels feed a pending set drained lowest index first.
module key_typematic
  import key_typematic_pkg::*;
#(
  parameter int unsigned        NKEYS         = DefNkeys,
  parameter int unsigned        DEBOUNCE      = 3,
  parameter int unsigned        REPEAT_DELAY  = 4,
  parameter int unsigned        REPEAT_PERIOD = 2,
  parameter logic [8*NKEYS-1:0] CODES         = DefCodes,
  parameter logic [NKEYS-1:0]   REPEAT_MASK   = DefRepeatMask,
  parameter logic [NKEYS-1:0]   TYPE_MASK     = DefTypeMask
) (
  input  logic             clk,
  input  logic             i_arst,
  input  logic             i_sclr,
  input  logic             i_en,
  input  logic [NKEYS-1:0] i_key_n,
  input  logic             i_asciiex_rdy,
  output logic [7:0]       o_asciiex,
  output logic             o_type,
  output logic             o_asciiex_en,
  output logic             o_overrun
);

  logic [NKEYS-1:0] w_event, r_pending, w_pending_d, w_sel_oh, w_take, w_drop;
  logic             w_load, w_any;
  logic [7:0]       w_code, r_asciiex;
  logic             w_type, r_type, r_asciiex_en, r_overrun;

  for (genvar k = 0; k < NKEYS; k++) begin : g_chan
    key_channel #(
      .DEBOUNCE      (DEBOUNCE),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REPEAT_EN     (REPEAT_MASK[k])
    ) u_chan (
      .clk     (clk),
      .i_arst  (i_arst),
      .i_sclr  (i_sclr),
      .i_en    (i_en),
      .i_key_n (i_key_n[k]),
      .o_event (w_event[k])
    );
  end

  assign w_load   = !r_asciiex_en || i_asciiex_rdy;
  // Isolate the lowest set pending bit.
  assign w_sel_oh = r_pending & (~r_pending + NKEYS'(1));
  assign w_any    = |r_pending;
  assign w_take   = w_load ? w_sel_oh : '0;
  // A new event collides only with a pending bit that is not leaving this cycle.
  assign w_drop      = w_event & r_pending & ~w_take;
  assign w_pending_d = (r_pending & ~w_take) | w_event;

  assign o_asciiex    = r_asciiex;
  assign o_type       = r_type;
  assign o_asciiex_en = r_asciiex_en;
  assign o_overrun    = r_overrun;

  // Code and type lookup for the selected key.
  always_comb begin
    w_code = '0;
    w_type = 1'b0;
    for (int k = 0; k < int'(NKEYS); k++) begin
      if (w_sel_oh[k]) begin
        w_code = CODES[8*k +: 8];
        w_type = TYPE_MASK[k];
      end
    end
  end

  // Pending set and output register with valid/ready handshake.
  always_ff @(posedge clk or posedge i_arst) begin
    if (i_arst) begin
      r_pending    <= '0;
      r_asciiex    <= 8'h00;
      r_type       <= 1'b0;
      r_asciiex_en <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (i_sclr) begin
      r_pending    <= '0;
      r_asciiex    <= 8'h00;
      r_type       <= 1'b0;
      r_asciiex_en <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_pending <= w_pending_d;
      r_overrun <= |w_drop;
      if (w_load) begin
        if (w_any) begin
          r_asciiex    <= w_code;
          r_type       <= w_type;
          r_asciiex_en <= 1'b1;
        end else begin
          r_asciiex_en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_typematic.sv
// Self-checking bench for key_typematic with a behavioural event/queue model.
module tb_key_typematic;

  localparam int NK = 5;
  localparam int DB = 3;
  localparam int RD = 4;
  localparam int RP = 2;

  logic       clk = 1'b0;
  logic       i_arst = 1'b1;
  logic       i_sclr = 1'b0;
  logic       i_en = 1'b1;
  logic       i_asciiex_rdy = 1'b1;
  logic [4:0] i_key_n = 5'b11111;
  logic [7:0] o_asciiex;
  logic       o_type, o_asciiex_en, o_overrun;

  key_typematic dut (
    .clk           (clk),
    .i_arst        (i_arst),
    .i_sclr        (i_sclr),
    .i_en          (i_en),
    .i_key_n       (i_key_n),
    .i_asciiex_rdy (i_asciiex_rdy),
    .o_asciiex     (o_asciiex),
    .o_type        (o_type),
    .o_asciiex_en  (o_asciiex_en),
    .o_overrun     (o_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_on   = 1'b0;
  int ovr_cnt  = 0;
  logic [8:0] tr_code[$];
  int         tr_cyc[$];

  // Model state: key level as seen after the 2-flop delay, debounced level,
  // run length of disagreeing ticks, ticks since press, pending set, output.
  bit         m_s1[NK], m_s2[NK], m_lvl[NK], m_evt_now[NK], m_evt_nxt[NK], m_pend[NK];
  int         m_run[NK], m_age[NK];
  logic [7:0] m_code;
  bit         m_type, m_en, m_ovr;

  function automatic logic [7:0] code_of(input int k);
    case (k)
      0: return 8'h02;
      1: return 8'h03;
      2: return 8'h04;
      3: return 8'h41;
      default: return 8'h08;
    endcase
  endfunction

  function automatic bit type_of(input int k);
    return k >= 3;
  endfunction

  function automatic bit rep_of(input int k);
    return k != 3;
  endfunction

  function automatic void model_step();
    int sel;
    bit drop, flipped;
    if (i_arst || i_sclr) begin
      for (int k = 0; k < NK; k++) begin
        m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_evt_now[k] = 0; m_evt_nxt[k] = 0;
        m_pend[k] = 0; m_run[k] = 0; m_age[k] = 0;
      end
      m_code = 8'h00; m_type = 0; m_en = 0; m_ovr = 0;
      return;
    end
    // Output stage: take lowest pending key whenever the slot is free or accepted.
    if (!m_en || i_asciiex_rdy) begin
      sel = -1;
      for (int k = 0; k < NK; k++) if (m_pend[k] && sel < 0) sel = k;
      if (sel >= 0) begin
        m_code = code_of(sel); m_type = type_of(sel); m_en = 1; m_pend[sel] = 0;
      end else begin
        m_en = 0;
      end
    end
    drop = 0;
    for (int k = 0; k < NK; k++) begin
      if (m_evt_now[k]) begin
        if (m_pend[k]) drop = 1;
        else m_pend[k] = 1;
      end
    end
    m_ovr = drop;
    for (int k = 0; k < NK; k++) begin
      m_evt_nxt[k] = 0;
      flipped = 0;
      if (i_en) begin
        if (m_s2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            m_lvl[k] = !m_lvl[k];
            m_run[k] = 0;
            flipped  = 1;
            if (m_lvl[k]) begin
              m_age[k]     = 0;
              m_evt_nxt[k] = 1;
            end
          end
        end else begin
          m_run[k] = 0;
        end
        if (!flipped && m_lvl[k] && rep_of(k)) begin
          m_age[k]++;
          if (m_age[k] >= RD && ((m_age[k] - RD) % RP) == 0) m_evt_nxt[k] = 1;
        end
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = !i_key_n[k];
    end
    for (int k = 0; k < NK; k++) m_evt_now[k] = m_evt_nxt[k];
  endfunction

  initial forever begin
    @(posedge clk or posedge i_arst);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Cycle compare against the model plus a transfer/overrun log.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      n_checks++;
      if ({o_asciiex, o_type, o_asciiex_en, o_overrun} !== {m_code, m_type, m_en, m_ovr}) begin
        n_fail++;
        $display("FAIL model_cmp cyc=%0d got code=%h type=%b en=%b ovr=%b exp code=%h type=%b en=%b ovr=%b",
                 cyc, o_asciiex, o_type, o_asciiex_en, o_overrun, m_code, m_type, m_en, m_ovr);
      end
    end
    if (o_asciiex_en === 1'b1 && i_asciiex_rdy === 1'b1) begin
      tr_code.push_back({o_type, o_asciiex});
      tr_cyc.push_back(cyc);
    end
    if (o_overrun === 1'b1) ovr_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    tr_code.delete();
    tr_cyc.delete();
  endtask

  initial begin
    int ovr0, c0, bad;
    bit seen;
    #12;
    check("reset_outputs", {o_asciiex, o_type, o_asciiex_en, o_overrun}, 0);
    tick(1);
    i_arst = 1'b0;
    chk_on = 1'b1;
    tick(3);

    // Glitch on key3 is ignored; a clean press gives one typing code, no repeat.
    clear_log();
    i_key_n[3] = 1'b0; tick(2);
    i_key_n[3] = 1'b1; tick(5);
    i_key_n[3] = 1'b0; tick(10);
    i_key_n[3] = 1'b1; tick(12);
    check("k3_count", tr_code.size(), 1);
    if (tr_code.size() > 0) check("k3_code", tr_code[0], 9'h141);

    // Key0 held 20 ticks: press then repeats at +4, +6, ..., nothing after release.
    clear_log();
    i_key_n[0] = 1'b0; tick(20);
    i_key_n[0] = 1'b1; tick(14);
    check("k0_count", tr_code.size(), 9);
    if (tr_code.size() >= 3) begin
      check("k0_gap1", tr_cyc[1] - tr_cyc[0], 4);
      check("k0_gap2", tr_cyc[2] - tr_cyc[1], 2);
    end
    bad = 0;
    foreach (tr_code[i]) if (tr_code[i] != 9'h002) bad++;
    check("k0_codes", bad, 0);

    // Keys 4 and 1 together: key1 first, key4 next cycle, no overrun.
    clear_log();
    ovr0 = ovr_cnt;
    i_key_n = 5'b01101; tick(10);
    i_key_n = 5'b11111; tick(14);
    if (tr_code.size() >= 2) begin
      check("pair_first", tr_code[0], 9'h003);
      check("pair_second", tr_code[1], 9'h108);
      check("pair_gap", tr_cyc[1] - tr_cyc[0], 1);
    end else begin
      check("pair_count", tr_code.size(), 2);
    end
    check("pair_overrun", ovr_cnt - ovr0, 0);

    // Backpressure during repeat: output holds, repeats overrun, one event buffered.
    i_asciiex_rdy = 1'b0;
    ovr0 = ovr_cnt;
    i_key_n[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (o_asciiex_en === 1'b1) seen = 1;
    end
    check("bp_valid_seen", seen, 1);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("bp_hold", {o_asciiex_en, o_asciiex}, 9'h102);
    end
    i_key_n[0] = 1'b1; tick(8);
    clear_log();
    i_asciiex_rdy = 1'b1; tick(6);
    check("bp_drain_count", tr_code.size(), 2);
    check("bp_overrun_seen", (ovr_cnt - ovr0) > 0, 1);

    // Async reset in the middle of repeating; key held through release.
    i_key_n[0] = 1'b0; tick(14);
    #1 i_arst = 1'b1;
    #1 check("arst_outputs", {o_asciiex, o_type, o_asciiex_en, o_overrun}, 0);
    tick(2);
    clear_log();
    i_arst = 1'b0;
    c0 = cyc;
    tick(10);
    if (tr_code.size() > 0) begin
      check("arst_repress_code", tr_code[0], 9'h002);
      check("arst_latency", tr_cyc[0] - c0, 7);
    end else begin
      check("arst_repress_count", tr_code.size(), 1);
    end
    i_key_n[0] = 1'b1; tick(12);

    // Tick enable every other cycle on key2: only counters slow down.
    clear_log();
    i_key_n[2] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      i_en = ~i_en;
      if (i == 16) i_key_n[2] = 1'b1;
      tick(1);
    end
    i_en = 1'b1; tick(12);
    if (tr_code.size() > 0) check("en_first_code", tr_code[0], 9'h004);
    else check("en_count", tr_code.size(), 1);

    // Synchronous clear while key4 repeats.
    i_key_n[4] = 1'b0; tick(14);
    i_sclr = 1'b1; tick(1);
    check("sclr_outputs", {o_asciiex, o_type, o_asciiex_en, o_overrun}, 0);
    i_sclr = 1'b0; tick(12);
    i_key_n[4] = 1'b1; tick(12);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
